// File: rtl/wb_slave_regfile_pkg.sv
// Shared types and constants for the Wishbone register-file slave.
package wb_slave_regfile_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam int REG_ID       = 0;
   localparam int REG_STATUS   = 1;
   localparam int REG_RW_FIRST = 2;
   localparam int CNT_WIDTH    = 16;

endpackage

// File: rtl/wb_slave_addr_decode.sv
// Classifies a Wishbone request against one aligned slave window.
module wb_slave_addr_decode #(
   parameter int              aw        = 32,
   parameter int              NUM_REGS  = 16,
   parameter logic [aw-1:0]   BASE_ADDR = 32'h4000_0000,
   parameter int              IW        = $clog2(NUM_REGS)
) (
   input  logic [aw-1:0] i_adr,
   input  logic          i_cyc,
   input  logic          i_stb,
   output logic          o_hit,
   output logic [IW-1:0] o_idx,
   output logic          o_mis
);

   logic w_in_win;

   // Window is aligned to its size, so comparing the upper bits is exact.
   assign w_in_win = (i_adr[aw-1:IW+2] == BASE_ADDR[aw-1:IW+2]);
   assign o_hit    = i_cyc & i_stb & w_in_win;
   assign o_idx    = i_adr[IW+1:2];
   assign o_mis    = |i_adr[1:0];

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave: ID, status counters and byte-lane RW registers.
module wb_slave_regfile
   import wb_slave_regfile_pkg::*;
#(
   parameter int              dw          = 32,
   parameter int              aw          = 32,
   parameter int              NUM_REGS    = 16,
   parameter logic [aw-1:0]   BASE_ADDR   = 32'h4000_0000,
   parameter int              WAIT_STATES = 1,
   parameter logic [dw-1:0]   ID_VALUE    = 32'hC0DE_0001,
   parameter int              CNT_W       = CNT_WIDTH
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic [aw-1:0] wb_adr_i,
   input  logic [dw-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   output logic [dw-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o
);

   localparam int IW = $clog2(NUM_REGS);
   localparam logic [IW-1:0] IDX_ID = IW'(REG_ID);
   localparam logic [IW-1:0] IDX_ST = IW'(REG_STATUS);
   localparam logic [IW-1:0] IDX_RW = IW'(REG_RW_FIRST);
   localparam logic [3:0] WC_INIT =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam bit NO_WAIT = (WAIT_STATES == 0);

   state_e           r_state;
   logic [3:0]       r_wcnt;
   logic [IW-1:0]    r_idx;
   logic             r_mis;
   logic             r_we;
   logic [3:0]       r_sel;
   logic [dw-1:0]    r_wdat;
   logic [dw-1:0]    r_regs [NUM_REGS];
   logic [CNT_W-1:0] r_txn;
   logic [CNT_W-1:0] r_err;

   logic             w_hit;
   logic [IW-1:0]    w_dec_idx;
   logic             w_dec_mis;
   logic             w_idle;
   logic [IW-1:0]    w_idx;
   logic             w_mis;
   logic             w_we;
   logic [3:0]       w_sel;
   logic [dw-1:0]    w_wdat;
   logic             w_fire;
   logic             w_st_wr;
   logic [dw-1:0]    w_rdata;

   wb_slave_addr_decode #(
      .aw        (aw),
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE_ADDR),
      .IW        (IW)
   ) u_dec (
      .i_adr (wb_adr_i),
      .i_cyc (wb_cyc_i),
      .i_stb (wb_stb_i),
      .o_hit (w_hit),
      .o_idx (w_dec_idx),
      .o_mis (w_dec_mis)
   );

   // Without wait states the response is built from the live bus.
   assign w_idle  = (r_state == IDLE);
   assign w_idx   = w_idle ? w_dec_idx : r_idx;
   assign w_mis   = w_idle ? w_dec_mis : r_mis;
   assign w_we    = w_idle ? wb_we_i   : r_we;
   assign w_sel   = w_idle ? wb_sel_i  : r_sel;
   assign w_wdat  = w_idle ? wb_dat_i  : r_wdat;
   assign w_fire  = (w_idle & w_hit & NO_WAIT)
                  | ((r_state == WAIT) & wb_cyc_i & (r_wcnt == 4'd0));
   assign w_st_wr = w_we & (w_idx == IDX_ST);

   always_comb begin
      w_rdata = r_regs[w_idx];
      unique case (1'b1)
         (w_idx == IDX_ID): w_rdata = ID_VALUE;
         (w_idx == IDX_ST): w_rdata = {16'(r_err), 16'(r_txn)};
         default:           w_rdata = r_regs[w_idx];
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_state  <= IDLE;
         r_wcnt   <= '0;
         r_idx    <= '0;
         r_mis    <= 1'b0;
         r_we     <= 1'b0;
         r_sel    <= '0;
         r_wdat   <= '0;
         r_txn    <= '0;
         r_err    <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_idx  <= w_dec_idx;
                  r_mis  <= w_dec_mis;
                  r_we   <= wb_we_i;
                  r_sel  <= wb_sel_i;
                  r_wdat <= wb_dat_i;
                  r_wcnt <= WC_INIT;
                  r_state <= NO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (!wb_cyc_i)
                  r_state <= IDLE;
               else if (r_wcnt == 4'd0)
                  r_state <= RESP;
               else
                  r_wcnt <= r_wcnt - 4'd1;
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_fire) begin
            if (w_mis) begin
               wb_err_o <= 1'b1;
               wb_dat_o <= '0;
               if (r_err != '1) r_err <= r_err + 1'b1;
            end else begin
               wb_ack_o <= 1'b1;
               if (!w_we) wb_dat_o <= w_rdata;
               // The status clear must override this access's own count.
               if (w_st_wr) begin
                  r_txn <= '0;
                  r_err <= '0;
               end else begin
                  r_txn <= r_txn + 1'b1;
               end
               if (w_we && (w_idx >= IDX_RW)) begin
                  for (int b = 0; b < dw/8; b++)
                     if (w_sel[b])
                        r_regs[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Scoreboard bench for wb_slave_regfile across three wait-state builds.
module tb_wb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_i;
   logic [3:0]  sel;
   int          tgt;

   logic        cyc_a, cyc_b, cyc_c;
   logic [31:0] dat_a, dat_b, dat_c, dat;
   logic        ack_a, ack_b, ack_c, ack;
   logic        err_a, err_b, err_c, err;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] dat;
      logic        chk;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   assign cyc_a = cyc & (tgt == 0);
   assign cyc_b = cyc & (tgt == 1);
   assign cyc_c = cyc & (tgt == 2);
   assign ack = (tgt == 1) ? ack_b : (tgt == 2) ? ack_c : ack_a;
   assign err = (tgt == 1) ? err_b : (tgt == 2) ? err_c : err_a;
   assign dat = (tgt == 1) ? dat_b : (tgt == 2) ? dat_c : dat_a;

   wb_slave_regfile dut_a (
      .wb_clk (clk), .wb_rst (rst),
      .wb_adr_i (adr), .wb_dat_i (dat_i), .wb_sel_i (sel),
      .wb_we_i (we), .wb_cyc_i (cyc_a), .wb_stb_i (stb),
      .wb_dat_o (dat_a), .wb_ack_o (ack_a), .wb_err_o (err_a)
   );

   wb_slave_regfile #(.WAIT_STATES(3), .CNT_W(4)) dut_b (
      .wb_clk (clk), .wb_rst (rst),
      .wb_adr_i (adr), .wb_dat_i (dat_i), .wb_sel_i (sel),
      .wb_we_i (we), .wb_cyc_i (cyc_b), .wb_stb_i (stb),
      .wb_dat_o (dat_b), .wb_ack_o (ack_b), .wb_err_o (err_b)
   );

   wb_slave_regfile #(.WAIT_STATES(0)) dut_c (
      .wb_clk (clk), .wb_rst (rst),
      .wb_adr_i (adr), .wb_dat_i (dat_i), .wb_sel_i (sel),
      .wb_we_i (we), .wb_cyc_i (cyc_c), .wb_stb_i (stb),
      .wb_dat_o (dat_c), .wb_ack_o (ack_c), .wb_err_o (err_c)
   );

   function automatic int ws_of(int t);
      return (t == 1) ? 3 : (t == 2) ? 0 : 1;
   endfunction

   function automatic exp_t mk(logic a, logic e, logic [31:0] d,
                               logic c);
      exp_t x;
      x.ack = a;
      x.err = e;
      x.dat = d;
      x.chk = c;
      return x;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic access(input string nm, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic w, input logic keep,
                         input exp_t e);
      exp_t g;
      int   n;
      bit   done;
      sb.push_back(e);
      adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (ack || err) done = 1'b1;
      end
      g = sb.pop_front();
      n_run++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s timeout: no ack/err after %0d cycles", nm, n);
         cyc = 1'b0;
         stb = 1'b0;
         return;
      end
      if (n != ws_of(tgt) + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", nm, n,
                  ws_of(tgt) + 1);
      end
      n_run++;
      if (ack !== g.ack || err !== g.err) begin
         n_fail++;
         $display("FAIL %s resp: ack=%b err=%b want ack=%b err=%b",
                  nm, ack, err, g.ack, g.err);
      end
      if (g.chk) begin
         n_run++;
         if (dat !== g.dat) begin
            n_fail++;
            $display("FAIL %s data: got %h want %h", nm, dat, g.dat);
         end
      end
      if (!keep) begin
         cyc = 1'b0;
         stb = 1'b0;
      end
      @(negedge clk);
      n_run++;
      if (ack !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pulse: ack=%b err=%b want 0 0", nm, ack, err);
      end
   endtask

   task automatic rd(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
      access(nm, a, 32'h0, 4'hF, 1'b0, 1'b0, mk(1'b1, 1'b0, e, 1'b1));
   endtask

   task automatic wr(input string nm, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
      access(nm, a, d, s, 1'b1, 1'b0, mk(1'b1, 1'b0, 32'h0, 1'b0));
   endtask

   task automatic rd_err(input string nm, input logic [31:0] a);
      access(nm, a, 32'h0, 4'hF, 1'b0, 1'b0,
             mk(1'b0, 1'b1, 32'h0, 1'b1));
   endtask

   task automatic quiet(input string nm, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ack !== 1'b0 || err !== 1'b0) seen = 1'b1;
      end
      n_run++;
      if (seen) begin
         n_fail++;
         $display("FAIL %s quiet: response seen, want none", nm);
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int t = 0; t < 3; t++) begin
         tgt = t;
         #1;
         n_run++;
         if (ack !== 1'b0 || err !== 1'b0 || dat !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out[%0d]: ack=%b err=%b dat=%h want 0",
                     t, ack, err, dat);
         end
      end
      tgt = 0;
   endtask

   task automatic test_rw();
      tgt = 0;
      rd("id_read", 32'h4000_0000, 32'hC0DE_0001);
      do_reset();
      wr("lane_wr", 32'h4000_0008, 32'hAABB_CCDD, 4'b0101);
      rd("lane_rd", 32'h4000_0008, 32'h00BB_00DD);
      rd("status_txn2", 32'h4000_0004, 32'h0000_0002);
      wr("id_wr", 32'h4000_0000, 32'h1234_5678, 4'hF);
      rd("id_keep", 32'h4000_0000, 32'hC0DE_0001);
      wr("sel0_wr", 32'h4000_0008, 32'hFFFF_FFFF, 4'b0000);
      rd("sel0_rd", 32'h4000_0008, 32'h00BB_00DD);
      wr("top_wr", 32'h4000_003C, 32'h8765_4321, 4'b1010);
      rd("top_rd", 32'h4000_003C, 32'h8700_4300);
   endtask

   task automatic test_errors();
      tgt = 0;
      do_reset();
      rd_err("misalign_rd", 32'h4000_000A);
      adr = 32'h4000_0040; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      quiet("outside", 20);
      cyc = 1'b0;
      stb = 1'b0;
      n_run++;
      if (dat !== 32'h0) begin
         n_fail++;
         $display("FAIL outside_dat: got %h want 0", dat);
      end
      access("misalign_wr", 32'h4000_0009, 32'hFFFF_FFFF, 4'hF, 1'b1,
             1'b0, mk(1'b0, 1'b1, 32'h0, 1'b0));
      rd("misalign_nowr", 32'h4000_0008, 32'h0);
      rd("status_err", 32'h4000_0004, 32'h0002_0001);
   endtask

   task automatic test_abort();
      tgt = 1;
      do_reset();
      adr = 32'h4000_000C; dat_i = 32'h1234_5678; sel = 4'hF;
      we = 1'b1; cyc = 1'b1; stb = 1'b1;
      repeat (2) @(negedge clk);
      cyc = 1'b0;
      stb = 1'b0;
      quiet("abort", 10);
      rd("abort_reg", 32'h4000_000C, 32'h0);
      rd("abort_status", 32'h4000_0004, 32'h0000_0001);
   endtask

   task automatic test_saturate();
      tgt = 1;
      do_reset();
      for (int i = 0; i < 16; i++) rd_err("sat_err", 32'h4000_0001);
      rd("sat_status", 32'h4000_0004, 32'h000F_0000);
      wr("status_clr", 32'h4000_0004, 32'hFFFF_FFFF, 4'hF);
      rd("status_zero", 32'h4000_0004, 32'h0000_0000);
   endtask

   task automatic test_back_to_back();
      tgt = 2;
      do_reset();
      access("b2b_w2", 32'h4000_0008, 32'h1122_3344, 4'hF, 1'b1, 1'b1,
             mk(1'b1, 1'b0, 32'h0, 1'b0));
      access("b2b_w3", 32'h4000_000C, 32'h5566_7788, 4'b1100, 1'b1, 1'b1,
             mk(1'b1, 1'b0, 32'h0, 1'b0));
      access("b2b_r2", 32'h4000_0008, 32'h0, 4'hF, 1'b0, 1'b1,
             mk(1'b1, 1'b0, 32'h1122_3344, 1'b1));
      access("b2b_r3", 32'h4000_000C, 32'h0, 4'hF, 1'b0, 1'b1,
             mk(1'b1, 1'b0, 32'h5566_0000, 1'b1));
      access("b2b_st", 32'h4000_0004, 32'h0, 4'hF, 1'b0, 1'b0,
             mk(1'b1, 1'b0, 32'h0000_0004, 1'b1));
   endtask

   task automatic test_reset_mid();
      tgt = 0;
      do_reset();
      wr("pre_wr", 32'h4000_0014, 32'hFFFF_FFFF, 4'hF);
      rd("pre_rd", 32'h4000_0014, 32'hFFFF_FFFF);
      adr = 32'h4000_0018; dat_i = 32'hDEAD_BEEF; sel = 4'hF;
      we = 1'b1; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cyc = 1'b0;
      stb = 1'b0;
      n_run++;
      if (ack !== 1'b0 || err !== 1'b0 || dat !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_rst_out: ack=%b err=%b dat=%h want 0",
                  ack, err, dat);
      end
      quiet("mid_rst", 8);
      for (int i = 2; i < 16; i++)
         rd("post_rst_reg", 32'h4000_0000 + 32'(i * 4), 32'h0);
      rd("post_rst_status", 32'h4000_0004, 32'h0000_000E);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = '0; dat_i = '0; sel = '0; tgt = 0;
      test_reset();
      test_rw();
      test_errors();
      test_abort();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
